// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - branch mode codes and resolver state encoding
// Exports: BR_BEQ..BR_NEVER mode codes, state_t (ST_IDLE, ST_FLUSH).
package branch_pkg;

    localparam logic [2:0] BR_BEQ    = 3'd0;
    localparam logic [2:0] BR_BNE    = 3'd1;
    localparam logic [2:0] BR_BGTZ   = 3'd2;
    localparam logic [2:0] BR_BLEZ   = 3'd3;
    localparam logic [2:0] BR_BLTZ   = 3'd4;
    localparam logic [2:0] BR_BGEZ   = 3'd5;
    localparam logic [2:0] BR_ALWAYS = 3'd6;
    localparam logic [2:0] BR_NEVER  = 3'd7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - combinational branch condition evaluator
// Ports: Operand_A/Operand_B (DATA_WIDTH) in, Branch_Mode (3) in, Taken out.
module branch_cond
    import branch_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] Operand_A,
    input  logic [DATA_WIDTH-1:0] Operand_B,
    input  logic [2:0]            Branch_Mode,
    output logic                  Taken
);

    // Signed compares against zero reduce to the sign bit and a zero test.
    logic a_neg;
    logic a_zero;
    logic a_eq_b;

    assign a_neg  = Operand_A[DATA_WIDTH-1];
    assign a_zero = (Operand_A == '0);
    assign a_eq_b = (Operand_A == Operand_B);

    always_comb begin
        Taken = 1'b0;
        case (Branch_Mode)
            BR_BEQ:    Taken = a_eq_b;
            BR_BNE:    Taken = !a_eq_b;
            BR_BGTZ:   Taken = !a_neg && !a_zero;
            BR_BLEZ:   Taken = a_neg || a_zero;
            BR_BLTZ:   Taken = a_neg;
            BR_BGEZ:   Taken = !a_neg;
            BR_ALWAYS: Taken = 1'b1;
            BR_NEVER:  Taken = 1'b0;
            default:   Taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - EX-stage branch resolution and flush sequencer
// Ports: Clk, Reset (async, active-high); Branch_Valid, Branch_Mode, Operand_A,
// Operand_B, Target_Addr, Stall in; PCSrc, Branch_Target, Flush, Busy,
// Branch_Count, Taken_Count out.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Branch_Valid,
    input  logic [2:0]            Branch_Mode,
    input  logic [DATA_WIDTH-1:0] Operand_A,
    input  logic [DATA_WIDTH-1:0] Operand_B,
    input  logic [ADDR_WIDTH-1:0] Target_Addr,
    input  logic                  Stall,
    output logic                  PCSrc,
    output logic [ADDR_WIDTH-1:0] Branch_Target,
    output logic                  Flush,
    output logic                  Busy,
    output logic [CNT_WIDTH-1:0]  Branch_Count,
    output logic [CNT_WIDTH-1:0]  Taken_Count
);

    localparam logic [2:0]           FLUSH_LOAD = 3'(FLUSH_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};

    state_t                 state_q, state_d;
    logic [2:0]             fcnt_q, fcnt_d;
    logic                   pcsrc_q, pcsrc_d;
    logic [ADDR_WIDTH-1:0]  target_q, target_d;
    logic [CNT_WIDTH-1:0]   bcnt_q, bcnt_d;
    logic [CNT_WIDTH-1:0]   tcnt_q, tcnt_d;
    logic                   taken;
    logic                   accept;

    branch_cond #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cond (
        .Operand_A   (Operand_A),
        .Operand_B   (Operand_B),
        .Branch_Mode (Branch_Mode),
        .Taken       (taken)
    );

    // Branch_Valid is only honoured in IDLE; during FLUSH the EX instruction
    // is one of the squashed ones.
    assign accept = (state_q == ST_IDLE) && Branch_Valid && !Stall;

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        pcsrc_d  = 1'b0;
        target_d = target_q;
        bcnt_d   = bcnt_q;
        tcnt_d   = tcnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept && taken) begin
                    target_d = Target_Addr;
                    pcsrc_d  = 1'b1;
                    fcnt_d   = FLUSH_LOAD;
                    state_d  = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!Stall) begin
                    fcnt_d = fcnt_q - 3'd1;
                    if (fcnt_q <= 3'd1) begin
                        fcnt_d  = 3'd0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Statistics saturate rather than wrap.
        if (accept && bcnt_q != CNT_MAX) begin
            bcnt_d = bcnt_q + 1'b1;
        end
        if (accept && taken && tcnt_q != CNT_MAX) begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            fcnt_q   <= 3'd0;
            pcsrc_q  <= 1'b0;
            target_q <= '0;
            bcnt_q   <= '0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            pcsrc_q  <= pcsrc_d;
            target_q <= target_d;
            bcnt_q   <= bcnt_d;
            tcnt_q   <= tcnt_d;
        end
    end

    // Flush/Busy decode straight from the state register so an asserted
    // Reset removes them without waiting for a clock.
    assign PCSrc         = pcsrc_q;
    assign Branch_Target = target_q;
    assign Flush         = (state_q == ST_FLUSH);
    assign Busy          = (state_q == ST_FLUSH);
    assign Branch_Count  = bcnt_q;
    assign Taken_Count   = tcnt_q;

endmodule
